// File: rtl/neuron_acc_stream_if.sv
// Handshake bundle for neuron_acc_stream: product stream in, one group sum out.
// The master modport is the producer/consumer side; the slave modport is the accumulator.
interface neuron_acc_stream_if #(
  parameter int IN_W   = 20,
  parameter int BIAS_W = 22,
  parameter int ACC_W  = 22,
  parameter int CNT_W  = 10
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [IN_W-1:0]   in_data;
  logic                     in_last;
  logic signed [BIAS_W-1:0] bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]         out_count;
  logic                     out_ovf;
  logic                     out_trunc;

  modport master (
    output in_valid, in_data, in_last, bias, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf, out_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, bias, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf, out_trunc
  );
endinterface

// File: rtl/neuron_acc_stream.sv
// Streaming signed accumulator: bias + sum of products per group, one registered result per group.
// Latency: end beat at cycle N -> out_valid at N+1. Backpressure: in_ready low while a result waits.
// Build option ACC_SAT_EN: clamp on overflow instead of two's-complement wrap.
module neuron_acc_stream #(
  parameter int IN_W    = 20,
  parameter int BIAS_W  = 22,
  parameter int ACC_W   = 22,
  parameter int MAX_LEN = 784,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  neuron_acc_stream_if.slave bus
);
  typedef enum logic {S_ACCUM = 1'b0, S_DRAIN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_first;
  logic                    r_ovf;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;
  logic [CNT_W-1:0]        r_out_count;
  logic                    r_out_ovf;
  logic                    r_out_trunc;

  logic                    w_accept;
  logic                    w_end;
  logic                    w_out_fire;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic signed [ACC_W:0]   w_base;
  logic signed [ACC_W:0]   w_raw;
  logic                    w_ovf_beat;
  logic signed [ACC_W-1:0] w_result;

  assign w_accept   = bus.in_valid & (r_state == S_ACCUM);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_end      = w_accept & (bus.in_last | (w_cnt_inc == MAX_CNT));
  assign w_out_fire = r_out_valid & bus.out_ready;

  // One guard bit above ACC_W makes signed overflow a simple top-two-bit disagreement.
  always_comb begin
    w_base = r_first ? {{(ACC_W+1-BIAS_W){bus.bias[BIAS_W-1]}}, bus.bias}
                     : {r_acc[ACC_W-1], r_acc};
    w_raw      = w_base + {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    w_ovf_beat = w_raw[ACC_W] ^ w_raw[ACC_W-1];
    w_result   = w_raw[ACC_W-1:0];
`ifdef ACC_SAT_EN
    if (w_ovf_beat) begin
      w_result = w_raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACCUM: if (w_end)      w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_fire) w_state_nxt = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
      r_out_trunc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_end) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_first     <= 1'b1;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_count <= w_cnt_inc;
        r_out_ovf   <= r_ovf | w_ovf_beat;
        r_out_trunc <= ~bus.in_last;
      end else if (w_accept) begin
        r_acc   <= w_result;
        r_cnt   <= w_cnt_inc;
        r_first <= 1'b0;
        r_ovf   <= r_ovf | w_ovf_beat;
      end
      if (w_out_fire) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_trunc = r_out_trunc;
endmodule
